// File: rtl/fp_ci_pkg.sv
// Shared opcode, latency and state definitions for the FP custom-instruction master.
package fp_ci_pkg;

  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_SUB     = 2'd1;
  localparam logic [1:0] OP_MUL     = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam int unsigned ADD_LAT = 7;
  localparam int unsigned SUB_LAT = 7;
  localparam int unsigned MUL_LAT = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/fp_ci_master.sv
// Initiator for the multi-cycle Nios FP custom-instruction slave: one command in
// flight, start pulse, wait for done (with timeout), then a held response.
module fp_ci_master
  import fp_ci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned OPW            = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic [31:0]     ci_dataa,
  output logic [31:0]     ci_datab,
  output logic [OPW-1:0]  ci_n,
  output logic            ci_start,
  output logic            ci_clk_en,
  input  logic [31:0]     ci_result,
  input  logic            ci_done
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_q, state_d;
  logic            run_q;
  logic [TW-1:0]   timer_q;
  logic            accept;
  logic            op_illegal;
  logic            timer_last;

  assign accept     = cmd_valid && cmd_ready;
  assign op_illegal = (cmd_op == OPW'(OP_ILLEGAL));
  assign timer_last = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // run_q keeps cmd_ready and clk_en low until the first clock after reset.
  assign cmd_ready = run_q && (state_q == ST_IDLE);
  assign ci_clk_en = run_q;
  assign ci_start  = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = op_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ci_done || timer_last) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      timer_q  <= '0;
      ci_dataa <= '0;
      ci_datab <= '0;
      ci_n     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ci_n     <= cmd_op;
            ci_dataa <= cmd_a;
            ci_datab <= cmd_b;
            if (op_illegal) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        ST_ISSUE: timer_q <= '0;
        ST_WAIT: begin
          // done wins over a simultaneous timeout; timer saturates at the limit.
          if (ci_done) begin
            rsp_data <= ci_result;
            rsp_err  <= 1'b0;
          end else if (timer_last) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
          if (!ci_done && timer_q != TW'(TIMEOUT_CYCLES)) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_ci_master.sv
// Scoreboard bench for fp_ci_master with a behavioural FP custom-instruction slave stub.
module tb_fp_ci_master;
  import fp_ci_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [31:0] ci_dataa, ci_datab;
  logic [1:0]  ci_n;
  logic        ci_start, ci_clk_en;
  logic [31:0] ci_result;
  logic        ci_done;

  always #5 clk = ~clk;

  fp_ci_master #(.TIMEOUT_CYCLES(32), .OPW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_n(ci_n),
    .ci_start(ci_start), .ci_clk_en(ci_clk_en),
    .ci_result(ci_result), .ci_done(ci_done)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;
  exp_t sb[$];

  // Slave stub: counts its own latency from the start pulse, done high one cycle.
  logic        stub_done = 1'b0;
  logic        force_done = 1'b0;
  logic        stub_never = 1'b0;
  logic [31:0] stub_result = '0;
  int unsigned stub_cnt = 0;
  int unsigned starts = 0;
  int unsigned last_acc = 0;
  logic [1:0]  exp_n = '0;
  logic [31:0] exp_a = '0, exp_b = '0;

  assign ci_done   = stub_done | force_done;
  assign ci_result = stub_done ? stub_result : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (ci_start) begin
      starts++;
      check("start_cycle", cyc, last_acc + 1);
      check("start_clk_en", ci_clk_en, 1'b1);
      check("start_n", ci_n, exp_n);
      check("start_dataa", ci_dataa, exp_a);
      check("start_datab", ci_datab, exp_b);
      stub_cnt  = (ci_n == OP_MUL) ? MUL_LAT : ((ci_n == OP_SUB) ? SUB_LAT : ADD_LAT);
      stub_done = 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt--;
      stub_done = (stub_cnt == 0) && !stub_never;
    end else begin
      stub_done = 1'b0;
    end
  end

  // Monitor: checks held responses and pops the scoreboard on each handshake.
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_err = 1'b0;
  int unsigned first_cyc = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (!prev_valid || prev_hs) first_cyc = cyc;
      check("cmd_ready_in_resp", cmd_ready, 1'b0);
      if (prev_valid && !prev_hs) begin
        check("hold_data", rsp_data, prev_data);
        check("hold_err", rsp_err, prev_err);
      end
      if (rsp_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got data %h err %b, required no response (cycle %0d)",
                   rsp_data, rsp_err, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_err", rsp_err, mon_e.err);
          check("rsp_latency", first_cyc - mon_e.acc, mon_e.lat);
        end
      end
    end
    prev_valid = rsp_valid;
    prev_hs    = rsp_valid && rsp_ready;
    prev_data  = rsp_data;
    prev_err   = rsp_err;
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic never, input logic hold_done,
                      input logic [31:0] xdata, input logic xerr, input int unsigned xlat);
    int unsigned guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL cmd_ready_timeout: got cmd_ready 0, required 1 within 200 cycles");
      return;
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    exp_n       = op;
    exp_a       = a;
    exp_b       = b;
    stub_result = res;
    stub_never  = never;
    last_acc    = cyc;
    if (hold_done) force_done = 1'b1;
    sb.push_back('{xdata, xerr, cyc, xlat});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (hold_done) begin
      @(posedge clk);
      #1 force_done = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy || sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy %b pending %0d, required idle within 200 cycles",
               busy, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  logic        seen_rsp;
  int unsigned starts_before;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_ci_start", ci_start, 1'b0);
    check("rst_ci_clk_en", ci_clk_en, 1'b0);
    check("rst_ci_dataa", ci_dataa, 32'h0);
    check("rst_ci_datab", ci_datab, 32'h0);
    check("rst_ci_n", ci_n, 2'd0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    check("post_rst_clk_en", ci_clk_en, 1'b1);

    // 1.5 + 2.25 = 3.75
    send(OP_ADD, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 1'b0, 1'b0,
         32'h4070_0000, 1'b0, 2 + ADD_LAT);
    wait_idle();

    // 5 - 1.5 = 3.5, then 2 * 3 = 6, back to back
    send(OP_SUB, 32'h40A0_0000, 32'h3FC0_0000, 32'h4060_0000, 1'b0, 1'b0,
         32'h4060_0000, 1'b0, 2 + SUB_LAT);
    send(OP_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0,
         32'h40C0_0000, 1'b0, 2 + MUL_LAT);
    wait_idle();

    starts_before = starts;
    send(OP_ILLEGAL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0,
         32'h0, 1'b1, 1);
    wait_idle();
    check("illegal_no_start", starts, starts_before);

    // never-done slave, done forced high through IDLE and ISSUE
    send(OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h5555_AAAA, 1'b1, 1'b1,
         32'h0, 1'b1, 2 + 32);
    wait_idle();
    stub_never = 1'b0;

    // 3 * 3 = 9 with the response held off for 10 cycles
    rsp_ready = 1'b0;
    send(OP_MUL, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0,
         32'h4110_0000, 1'b0, 2 + MUL_LAT);
    begin
      int unsigned g = 0;
      @(negedge clk);
      while (!rsp_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("bp_rsp_valid_seen", rsp_valid, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("bp_still_valid", rsp_valid, 1'b1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_hs", busy, 1'b0);
    check("bp_cmd_ready_after_hs", cmd_ready, 1'b1);
    wait_idle();

    // reset pulsed in WAIT; the slave's late done must not produce a response
    send(OP_ADD, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0,
         32'h4080_0000, 1'b0, 2 + ADD_LAT);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check("mid_rst_clk_en", ci_clk_en, 1'b0);
    check("mid_rst_start", ci_start, 1'b0);
    check("mid_rst_dataa", ci_dataa, 32'h0);
    check("mid_rst_datab", ci_datab, 32'h0);
    check("mid_rst_n", ci_n, 2'd0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    seen_rsp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_rsp = seen_rsp | rsp_valid;
    end
    check("no_rsp_after_reset", seen_rsp, 1'b0);

    send(OP_ADD, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 1'b0, 1'b0,
         32'h4070_0000, 1'b0, 2 + ADD_LAT);
    wait_idle();
    check("start_count", starts, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_ci_master.md
Name: fp_ci_master

Overview:
- Initiator side of the multi-cycle Nios custom-instruction FP interface: accepts FP operation commands from a hardware datapath (valid/ready), drives dataa/datab/n/start/clk_en into the FP custom-instruction slave, waits for done, returns the result (valid/ready).
- Lets hardware accelerators reuse the FP add/sub/mul unit without the CPU; one transaction outstanding at a time, with a timeout guard.

Parameters:
- TIMEOUT_CYCLES, 32, max WAIT cycles without done before an error response (must exceed the largest slave latency, 7).
- OPW, 2, opcode width (matches slave n).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_op  in  2  0=add, 1=sub, 2=mul, 3=illegal
- cmd_a  in  32  IEEE-754 single operand A
- cmd_b  in  32  IEEE-754 single operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  FP result (0 on error)
- rsp_err  out  1  1 = timeout or illegal opcode
- busy  out  1  state != IDLE
- ci_dataa  out  32  to slave dataa
- ci_datab  out  32  to slave datab
- ci_n  out  2  to slave n
- ci_start  out  1  to slave start
- ci_clk_en  out  1  to slave clk_en
- ci_result  in  32  from slave result
- ci_done  in  1  from slave done

Behaviour:
- Reset (async, reset_n=0): state=IDLE; cmd_ready=0 while in reset, then 1; rsp_valid=0, rsp_data=0, rsp_err=0, ci_start=0, ci_clk_en=0, ci_dataa/datab=0, ci_n=0, timer=0.
- ci_clk_en=1 in every cycle out of reset (the slave pipelines must advance continuously).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch op/a/b into ci_n/ci_dataa/ci_datab. op<=2 -> ISSUE. op==3 -> RESP with rsp_err=1, rsp_data=0; slave not started.
- ISSUE: exactly one cycle; ci_start=1, operands on ci_* stable -> WAIT, timer cleared.
- WAIT: ci_start=0; ci_dataa/datab/n held. Slave done is free-running and may be high in the start cycle or at idle: ci_done is ignored in IDLE/ISSUE and sampled only in WAIT. On ci_done=1: capture ci_result into rsp_data, rsp_err=0 -> RESP. Otherwise timer++; when timer reaches TIMEOUT_CYCLES: rsp_data=0, rsp_err=1 -> RESP.
- RESP: rsp_valid=1 with rsp_data/rsp_err stable until rsp_ready; on the handshake cycle -> IDLE (cmd_ready high the next cycle; no same-cycle accept).
- Latency: command accepted in cycle T -> start in T+1 -> done in T+1+L (L=7 add/sub, 5 mul) -> rsp_valid from T+2+L. Throughput: one op per L+3 cycles minimum.
- Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready stays 0.
- Reset mid-operation (any state): immediate return to reset values; a late slave done after reset is ignored, because the master is not in WAIT.
- Timer width: clog2(TIMEOUT_CYCLES+1); saturates, no wrap.

Decomposition:
- Package fp_ci_pkg: opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ILLEGAL=3; state enum; latency constants ADD_LAT=7, SUB_LAT=7, MUL_LAT=5 (shared with the bench stub).
- Single module; no sub-module. The bench supplies a behavioural slave stub with latency per opcode and an optional never-done mode.

Test Plan:
- add: a=0x3FC00000 (1.5), b=0x40100000 (2.25) -> ci_start one cycle after accept, done 7 cycles after start, rsp_data=0x40700000 (3.75), rsp_err=0, rsp_valid the cycle after done.
- sub then mul back-to-back: 0x40A00000-0x3FC00000 -> 0x40600000; 0x40000000*0x40400000 -> 0x40C00000 (mul done 5 cycles after start); cmd_ready low between.
- illegal op=3 -> no ci_start pulse; rsp_valid the cycle after accept with rsp_err=1, rsp_data=0.
- stub never asserts done, with done held high during ISSUE -> done in ISSUE is ignored; after 32 WAIT cycles rsp_err=1, rsp_data=0.
- rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready=0; IDLE the cycle after the handshake.
- reset_n pulsed low mid-WAIT -> all outputs at reset values asynchronously; stub done afterwards produces no rsp_valid.
